ram_bus: RTL and testbench

Parametrised single-port synchronous RAM with a bus-slave front end. It is the successor to the fixed 32x32 memory used on the simple memory/bus path. It adds:
- configurable width and depth
- per-byte write enables
- a selectable read latency
- a hardware clear engine that zeroes the array after reset or on request, signalled through a `ready` handshake

It sits behind the bus decoder as the data-memory slave.

---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_core.sv | 55 +++++
 rtl/ram_bus.sv | 154 +++++++++++++++
 tb/tb_ram_bus.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared types and default constants for the ram_bus data-memory slave.
//   ram_state_t    : controller state (clear engine running / serving requests)
//   RAM_DATA_WIDTH : default word width in bits
//   RAM_ADDR_WIDTH : default word-address width
package ram_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } ram_state_t;

    localparam int RAM_DATA_WIDTH = 32;
    localparam int RAM_ADDR_WIDTH = 5;

endpackage

// File: rtl/ram_core.sv
// ram_core: single-port storage array with per-byte write enables and a
// registered read port. One access per edge: either a write or a read.
//   clk   : clock
//   rst   : synchronous active-high reset (clears only the read register)
//   we    : write strobe, bytes selected by be
//   re    : read strobe, rdata updated on the same edge
//   be    : byte write enables
//   addr  : word address
//   wdata : write data
//   rdata : registered read data
module ram_core
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic                    re,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Byte-masked write into the array; contents are never reset here.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (we && be[i]) begin
                mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Registered read: captures the array contents before this edge's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/ram_bus.sv
// ram_bus: parametrised bus-slave RAM with byte enables, 1- or 2-cycle read
// latency and a clear engine that zeroes the array after reset or on clr.
//   clk, rst   : clock, synchronous active-high reset
//   cen, wen   : request present / write(1) or read(0)
//   be, addr   : byte write enables, word address
//   din        : write data
//   clr        : one-cycle request to re-zero the array (ignored while clearing)
//   ready      : slave accepts requests
//   dout       : read data, zero in every slot that is not a read result
//   dout_valid : dout carries read data
module ram_bus
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH   = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH   = RAM_ADDR_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cen,
    input  logic                    wen,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    clr,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    ram_state_t state_r, state_next_s;
    logic [ADDR_WIDTH-1:0]   init_addr_r;
    logic                    ready_r;
    logic                    accept_s;
    logic                    core_we_s, core_re_s;
    logic [DATA_WIDTH/8-1:0] core_be_s;
    logic [ADDR_WIDTH-1:0]   core_addr_s;
    logic [DATA_WIDTH-1:0]   core_wdata_s;
    logic [DATA_WIDTH-1:0]   rdata_s;
    logic                    rd_vld_r, vld1_r, vld2_r;
    logic [DATA_WIDTH-1:0]   dout1_r, dout2_r;

    // ready_r mirrors state_r, so gating on it means no request is taken mid-clear.
    assign accept_s = cen & ready_r & ~rst;

    // State register, clear counter and registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_INIT;
            init_addr_r <= '0;
            ready_r     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_READY);
            if (state_r == ST_INIT) begin
                // Saturate on the last address so a pass never wraps.
                init_addr_r <= (init_addr_r == LAST_ADDR) ? init_addr_r : init_addr_r + ADDR_ONE;
            end else if (clr) begin
                init_addr_r <= '0;
            end else begin
                init_addr_r <= init_addr_r;
            end
        end
    end

    // Next-state: leave INIT once the last word is being cleared; clr restarts it.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_addr_r == LAST_ADDR) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_READY: begin
                if (clr) begin
                    state_next_s = ST_INIT;
                end else begin
                    state_next_s = ST_READY;
                end
            end
            default: state_next_s = ST_INIT;
        endcase
    end

    // Array port steering: clear engine owns the port in INIT, the bus in READY.
    always_comb begin
        core_we_s    = 1'b0;
        core_re_s    = 1'b0;
        core_be_s    = '0;
        core_addr_s  = '0;
        core_wdata_s = '0;
        case (state_r)
            ST_INIT: begin
                core_we_s   = ~rst;
                core_be_s   = '1;
                core_addr_s = init_addr_r;
            end
            ST_READY: begin
                core_we_s    = accept_s & wen;
                core_re_s    = accept_s & ~wen;
                core_be_s    = be;
                core_addr_s  = addr;
                core_wdata_s = din;
            end
            default: begin
                core_we_s = 1'b0;
            end
        endcase
    end

    ram_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .we    (core_we_s),
        .re    (core_re_s),
        .be    (core_be_s),
        .addr  (core_addr_s),
        .wdata (core_wdata_s),
        .rdata (rdata_s)
    );

    // Read pipeline: the valid tag follows the array read; data is forced to
    // zero in any slot that is not a read, and reset discards in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_r <= 1'b0;
            vld1_r   <= 1'b0;
            vld2_r   <= 1'b0;
            dout1_r  <= '0;
            dout2_r  <= '0;
        end else begin
            rd_vld_r <= core_re_s;
            vld1_r   <= rd_vld_r;
            dout1_r  <= rd_vld_r ? rdata_s : '0;
            vld2_r   <= vld1_r;
            dout2_r  <= dout1_r;
        end
    end

    assign ready      = ready_r;
    assign dout       = (READ_LATENCY == 2) ? dout2_r : dout1_r;
    assign dout_valid = (READ_LATENCY == 2) ? vld2_r : vld1_r;

endmodule

// File: tb/tb_ram_bus.sv
// tb_ram_bus: drives a latency-1 and a latency-2 ram_bus with the same
// stimulus and compares both against a behavioural memory model every cycle.
module tb_ram_bus;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int BW = DW / 8;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, cen = 1'b0, wen = 1'b0, clr = 1'b0;
    logic [BW-1:0] be = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din = '0;

    logic          ready1, vld1, ready2, vld2;
    logic [DW-1:0] dout1, dout2;

    ram_bus #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .cen(cen), .wen(wen), .be(be), .addr(addr),
        .din(din), .clr(clr), .ready(ready1), .dout(dout1), .dout_valid(vld1)
    );

    ram_bus #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .cen(cen), .wen(wen), .be(be), .addr(addr),
        .din(din), .clr(clr), .ready(ready2), .dout(dout2), .dout_valid(vld2)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mem_m [DEPTH];
    int            init_left = DEPTH;   // words still to clear; 0 means serving
    bit            seen_rst = 1'b0;
    logic          s_v = 1'b0, e1_v = 1'b0, e2_v = 1'b0;  // slot results: this edge, 1 ago, 2 ago
    logic [DW-1:0] s_d = '0, e1_d = '0, e2_d = '0;

    task automatic model_step();
        bit acc;
        if (rst) begin
            init_left = DEPTH;
            seen_rst = 1'b1;
            s_v = 1'b0; e1_v = 1'b0; e2_v = 1'b0;
            s_d = '0;   e1_d = '0;   e2_d = '0;
        end else begin
            e2_v = e1_v; e2_d = e1_d;
            e1_v = s_v;  e1_d = s_d;
            acc = cen && (init_left == 0);
            s_v = acc && !wen;
            s_d = s_v ? mem_m[addr] : '0;
            if (acc && wen) begin
                for (int i = 0; i < BW; i++) begin
                    if (be[i]) mem_m[addr][8*i +: 8] = din[8*i +: 8];
                end
            end
            if (init_left > 0) begin
                mem_m[DEPTH - init_left] = '0;
                init_left--;
            end else if (clr) begin
                init_left = DEPTH;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare process: every negedge once the model has seen a reset edge.
    initial begin
        forever begin
            @(negedge clk);
            if (seen_rst) begin
                check("ready_l1", 64'(ready1), 64'(init_left == 0));
                check("ready_l2", 64'(ready2), 64'(init_left == 0));
                check("dout_l1", 64'({vld1, dout1}), 64'({e1_v, e1_d}));
                check("dout_l2", 64'({vld2, dout2}), 64'({e2_v, e2_d}));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic r, input logic c, input logic w, input logic [BW-1:0] b,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic cl);
        rst = r; cen = c; wen = w; be = b; addr = a; din = d; clr = cl;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic cl);
        cyc(1'b0, 1'b1, 1'b0, '1, a, 32'hFFFF_FFFF, cl);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] b);
        cyc(1'b0, 1'b1, 1'b1, b, a, d, 1'b0);
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready1 && cnt < 100) begin
            cnt++;
            idle();
        end
    endtask

    int cnt;

    initial begin
        // Reset for two edges, then count not-ready cycles.
        cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        check("reset_ready_low", 64'({ready1, vld1, dout1}), 64'(0));
        wait_ready(cnt);
        check("reset_init_cycles", 64'(cnt), 64'(32));

        // Every address reads back zero after init.
        for (int a = 0; a < DEPTH; a++) rd(AW'(a), 1'b0);
        check("read_zero_last", 64'({vld1, dout1}), {31'd0, 1'b1, 32'h0000_0000});
        idle();

        // Byte-enable merge.
        wr(5'd3, 32'hDEAD_BEEF, 4'b1111);
        wr(5'd3, 32'h0000_0011, 4'b0001);
        rd(5'd3, 1'b0);
        idle();
        check("byte_write", 64'({vld1, dout1}), {31'd0, 1'b1, 32'hDEAD_BE11});

        // Write then read of the same address on consecutive edges.
        wr(5'd31, 32'h1234_5678, 4'b1111);
        rd(5'd31, 1'b0);
        check("b2b_write_slot", 64'({vld1, dout1}), 64'(0));
        idle();
        check("b2b_read", 64'({vld1, dout1}), {31'd0, 1'b1, 32'h1234_5678});

        // Streaming reads on the latency-2 instance.
        wr(5'd0, 32'h0000_000A, 4'b1111);
        wr(5'd1, 32'h0000_000B, 4'b1111);
        for (int i = 0; i < 8; i++) begin
            rd(AW'(i % 2), 1'b0);
            if (i >= 2) check("lat2_stream", 64'({vld2, dout2}),
                              {31'd0, 1'b1, ((i % 2) != 0) ? 32'h0000_000B : 32'h0000_000A});
        end
        idle(); idle(); idle();
        check("lat2_gap", 64'({vld2, dout2}), 64'(0));

        // clr together with a read; requests in the clear window are ignored.
        wr(5'd5, 32'h0000_0055, 4'b1111);
        rd(5'd5, 1'b1);
        check("clr_ready_drop", 64'(ready1), 64'(0));
        cnt = 1;
        wr(5'd5, 32'hCAFE_F00D, 4'b1111);
        check("clr_read_drain", 64'({vld1, dout1}), {31'd0, 1'b1, 32'h0000_0055});
        while (!ready1 && cnt < 100) begin
            cnt++;
            wr(5'd5, 32'hCAFE_F00D, 4'b1111);
        end
        check("clr_ready_cycles", 64'(cnt), 64'(32));
        rd(5'd5, 1'b0);
        idle();
        check("clr_zeroed", 64'({vld1, dout1}), {31'd0, 1'b1, 32'h0000_0000});

        // Reset at init count 10 restarts the full clear (clr mid-init ignored).
        cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, (i == 4) ? 1'b1 : 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        wait_ready(cnt);
        check("rst_mid_init_cycles", 64'(cnt), 64'(32));

        // Reset one cycle after a read is accepted discards it.
        wr(5'd2, 32'h0BAD_CAFE, 4'b1111);
        rd(5'd2, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        check("rst_read_l1", 64'(vld1), 64'(0));
        idle();
        check("rst_read_l2", 64'(vld2), 64'(0));
        wait_ready(cnt);
        check("rst_read_reinit", 64'(cnt), 64'(31));

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)),
                BW'($urandom_range(0, 15)),
                AW'($urandom_range(0, 7)),
                DW'($urandom),
                ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0);
        end
        idle(); idle(); idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
